slc3_sram: RTL
==============

# slc3_sram

Word-addressed on-chip memory subsystem directly downstream of the SLC-3 core's memory port. It consumes the core's `ADDR`, `OE`, `WE` and `Data_to_SRAM`, and returns `Data_from_SRAM` with one cycle of read latency. After every reset, a boot engine copies a program image from an on-chip ROM into RAM and holds the core off until the copy completes. It also reports out-of-range accesses and counts accepted writes for debug display.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM depth is 2^ADDR_W 16-bit words.
- `INIT_LEN`, default 64: number of words copied from ROM at boot; 0 ≤ INIT_LEN ≤ 2^ADDR_W, otherwise an elaboration error.

Ports:
- `Clk`  in  1  — single clock; all state updates on the rising edge.
- `Reset_n`  in  1  — synchronous, active-low reset.
- `ADDR`  in  16  — word address from the core.
- `OE`  in  1  — read enable, active-high.
- `WE`  in  1  — write enable, active-high.
- `Data_to_SRAM`  in  16  — write data.
- `Data_from_SRAM`  out  16  — registered read data.
- `init_done`  out  1  — boot copy complete; CPU accesses are honoured.
- `cpu_hold`  out  1  — equals `~init_done`; used by the top level to hold the core in reset.
- `addr_err`  out  1  — sticky flag, set by any CPU access with `ADDR[15:ADDR_W] != 0`.
- `wr_count`  out  16  — count of accepted CPU writes; saturates at 16'hFFFF.

## Operation
- States: `S_BOOT` and `S_RUN`. Reset forces `S_BOOT` and clears the boot index to 0.
- `S_BOOT` behaviour:
  - Each cycle writes `rom[idx]` to `ram[idx]`, then increments `idx`.
  - When `idx == INIT_LEN-1` is written, the block moves to `S_RUN`.
  - If INIT_LEN == 0, `S_BOOT` lasts exactly one cycle and writes nothing.
  - All CPU `OE`/`WE` inputs are ignored: no RAM write, `Data_from_SRAM` holds its value, `addr_err` and `wr_count` are unchanged.
- `S_RUN` behaviour:
  - Write (`WE=1`, in range): `ram[ADDR[ADDR_W-1:0]] <= Data_to_SRAM`; `wr_count` increments (saturating).
  - Read (`OE=1`, `WE=0`, in range): `Data_from_SRAM <= ram[ADDR]`.
  - `OE=1` and `WE=1` together: the write takes place and `Data_from_SRAM <= Data_to_SRAM` (write-first).
  - Out of range, with `OE` or `WE` set: the write is dropped, `Data_from_SRAM <= 16'h0000`, `addr_err <= 1`, and `wr_count` is unchanged.
  - `OE=0` and `WE=0`: `Data_from_SRAM` holds its value.
- `S_RUN` exits only on reset.
- RAM array is not cleared by reset:
  - Words 0..INIT_LEN-1 are reloaded at each boot.
  - Words at INIT_LEN and above keep their contents across reset.
  - Power-up content is all zero.

## Timing
- Reset values: `Data_from_SRAM`=0, `init_done`=0, `cpu_hold`=1, `addr_err`=0, `wr_count`=0.
- Edge numbering: edge 1 is the first rising edge with `Reset_n`=1.
- Boot timing:
  - Word k is written at edge k+1.
  - `init_done` rises after edge max(INIT_LEN,1), so boot takes INIT_LEN cycles (1 cycle when INIT_LEN=0).
- Read latency is 1 cycle: with `ADDR`/`OE` presented before edge n, data is valid after edge n and stays stable until the next qualifying access.
- Writes commit at the edge where `WE` is sampled high. A read of the same address in the next cycle returns the new data.
- Reset asserted mid-boot or mid-run takes effect at that edge: the block returns to `S_BOOT` and the boot copy restarts from index 0.
- No handshake. The core's fixed multi-cycle memory states are sufficient for the 1-cycle latency.

## Configuration
- `SLC3_SRAM_BOOT_EN`
  - Defined: ROM sub-module and boot copy are present, with behaviour as described above.
  - Undefined: no ROM is built, and `S_BOOT` always lasts exactly one cycle, so `init_done` rises after edge 1. RAM retains its contents (zero at power-up). `INIT_LEN` is ignored.

## Structure
- Package `slc3_sram_pkg` holds:
  - the state enum (`S_BOOT`, `S_RUN`);
  - the default `ADDR_W` and `INIT_LEN` constants;
  - the 16'hFFFF saturation constant.
- Sub-module `sram_boot_rom`: combinational word lookup, input `idx` and output 16-bit word; contains the program image. Instantiated only under `SLC3_SRAM_BOOT_EN`.

## Test plan
- Boot: INIT_LEN=4, ROM = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}; release reset → `init_done` rises after edge 4; reading addresses 0..3 returns the ROM words, each 1 cycle after `OE`.
- CPU access during boot: `WE=1`, `ADDR`=2, data 16'hFFFF during boot → ignored; after boot, `ram[2]` = 16'h9ABC and `wr_count`=0.
- Write then read: write 16'hBEEF to `ADDR`=16'h0010, then read next cycle → `Data_from_SRAM`=16'hBEEF and `wr_count`=1. With `OE`+`WE` together, data 16'hCAFE → output 16'hCAFE after the same edge.
- Out of range: `ADDR`=16'h0400 with `ADDR_W`=10, `WE=1` → no RAM change, `addr_err`=1 and stays 1; a read of 16'h8000 returns 16'h0000.
- Reset mid-run: write 16'hAAAA to address 100 and 16'h5555 to address 1, then pulse `Reset_n` low for 1 cycle → `init_done`=0 for 4 cycles; afterwards address 1 = 16'h5678 and address 100 = 16'hAAAA; `wr_count`=0 and `addr_err`=0.
- Saturation: force 65536 in-range writes → `wr_count` stays at 16'hFFFF.

Source files
------------

// File: rtl/slc3_sram_pkg.sv
// Shared types and constants for the SLC-3 on-chip SRAM subsystem.
package slc3_sram_pkg;

    localparam int unsigned WORD_W       = 16;
    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_INIT_LEN = 64;
    localparam logic [WORD_W-1:0] WR_COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_boot_rom.sv
// Boot program image: combinational word lookup by index.
module sram_boot_rom
    import slc3_sram_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_ADDR_W
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] word
);

    // Beyond the fixed program prologue the image is a deterministic fill pattern.
    always_comb begin
        case (32'(idx))
            32'd0:   word = 16'h1234;
            32'd1:   word = 16'h5678;
            32'd2:   word = 16'h9ABC;
            32'd3:   word = 16'hDEF0;
            default: word = WORD_W'(idx) ^ 16'hA5A5;
        endcase
    end

endmodule

// File: rtl/slc3_sram.sv
// SLC-3 word-addressed SRAM with boot copy from ROM, address-error flag and write counter.
// Boot copy from ROM is built only when SLC3_SRAM_BOOT_EN is defined.
module slc3_sram
    import slc3_sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INIT_LEN = DEF_INIT_LEN
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [15:0]       ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [WORD_W-1:0] Data_to_SRAM,
    output logic [WORD_W-1:0] Data_from_SRAM,
    output logic              init_done,
    output logic              cpu_hold,
    output logic              addr_err,
    output logic [15:0]       wr_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef SLC3_SRAM_BOOT_EN
    localparam int unsigned BOOT_LEN = INIT_LEN;
`else
    localparam int unsigned BOOT_LEN = 0;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((BOOT_LEN == 0) ? 0 : BOOT_LEN - 1);

    generate
        if (INIT_LEN > DEPTH) begin : g_bad_init_len
            $error("slc3_sram: INIT_LEN exceeds RAM depth");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   ram_addr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [WORD_W-1:0]   ram_wdata;
    logic [WORD_W-1:0]   rom_word;
    logic                ram_we;
    logic                cpu_wr;
    logic                cpu_rd;
    logic                cpu_err;
    logic                in_range;
    logic [WORD_W-1:0]   mem [DEPTH];

`ifdef SLC3_SRAM_BOOT_EN
    sram_boot_rom #(.IDX_W(ADDR_W)) u_rom (
        .idx  (idx_q),
        .word (rom_word)
    );
`else
    assign rom_word = '0;
`endif

    assign in_range = (ADDR >> ADDR_W) == 16'h0000;
    assign cpu_addr = ADDR[ADDR_W-1:0];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_BOOT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Boot owns the RAM port; CPU requests are only decoded in S_RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = Data_to_SRAM;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_err   = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (BOOT_LEN == 0) begin
                    state_d = S_RUN;
                end else begin
                    ram_we    = 1'b1;
                    ram_addr  = idx_q;
                    ram_wdata = rom_word;
                    idx_d     = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (OE || WE) begin
                    if (!in_range) begin
                        cpu_err = 1'b1;
                    end else if (WE) begin
                        ram_we = 1'b1;
                        cpu_wr = 1'b1;
                    end else begin
                        cpu_rd = 1'b1;
                    end
                end
            end
        endcase
    end

    // RAM has no reset so words above the boot image survive a reset.
    always_ff @(posedge Clk) begin
        if (Reset_n && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Data_from_SRAM <= '0;
            init_done      <= 1'b0;
            cpu_hold       <= 1'b1;
            addr_err       <= 1'b0;
            wr_count       <= '0;
        end else begin
            init_done <= (state_d == S_RUN);
            cpu_hold  <= (state_d != S_RUN);
            if (cpu_err) begin
                Data_from_SRAM <= '0;
                addr_err       <= 1'b1;
            end else if (cpu_rd) begin
                Data_from_SRAM <= mem[cpu_addr];
            end else if (cpu_wr && OE) begin
                Data_from_SRAM <= Data_to_SRAM;
            end
            if (cpu_wr && (wr_count != WR_COUNT_MAX)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule
